// File: rtl/vga_pkg.sv
// vga_pkg: shared timing types and constants for the VGA timing generator.
//   vga_timing_t : one complete timing set (porches, sync widths, polarities)
//   VGA_640X480  : 640x480 set, 800 x 521 total
//   VGA_800X600  : 800x600 set, 1056 x 628 total
//   vga_htot / vga_vtot : total pixels per line / lines per frame of a set
package vga_pkg;

    typedef struct packed {
        logic [11:0] hvid;
        logic [11:0] hfp;
        logic [11:0] hs;
        logic [11:0] hbp;
        logic [11:0] vvid;
        logic [11:0] vfp;
        logic [11:0] vs;
        logic [11:0] vbp;
        logic        hpol;
        logic        vpol;
    } vga_timing_t;

    localparam vga_timing_t VGA_640X480 = '{
        hvid: 12'd640, hfp: 12'd16, hs: 12'd96,  hbp: 12'd48,
        vvid: 12'd480, vfp: 12'd10, vs: 12'd2,   vbp: 12'd29,
        hpol: 1'b1,    vpol: 1'b1
    };

    localparam vga_timing_t VGA_800X600 = '{
        hvid: 12'd800, hfp: 12'd40, hs: 12'd128, hbp: 12'd88,
        vvid: 12'd600, vfp: 12'd1,  vs: 12'd4,   vbp: 12'd23,
        hpol: 1'b1,    vpol: 1'b1
    };

    // 14 bits hold the sum of four 12-bit fields without overflow.
    function automatic logic [13:0] vga_htot(input vga_timing_t t);
        return {2'b00, t.hvid} + {2'b00, t.hfp} + {2'b00, t.hs} + {2'b00, t.hbp};
    endfunction

    function automatic logic [13:0] vga_vtot(input vga_timing_t t);
        return {2'b00, t.vvid} + {2'b00, t.vfp} + {2'b00, t.vs} + {2'b00, t.vbp};
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: wrap counter for one screen axis.
//   clk_25   in  pixel-domain clock
//   n_rst    in  synchronous active-low reset (count -> 0)
//   adv      in  advance this cycle
//   term     in  terminal count (total-1) of the active timing set
//   cnt      out current count (registered)
//   cnt_nxt  out count after this edge (combinational look-ahead)
//   at_term  out count is at or beyond term; wraps on the next advance
module vga_axis_counter #(
    parameter int CW = 11
) (
    input  logic          clk_25,
    input  logic          n_rst,
    input  logic          adv,
    input  logic [CW-1:0] term,
    output logic [CW-1:0] cnt,
    output logic [CW-1:0] cnt_nxt,
    output logic          at_term
);

    logic [CW-1:0] cnt_q, cnt_d;

    // >= rather than == so a count left out of range (e.g. after the
    // terminal shrinks) still wraps on the next advance.
    always_comb begin
        at_term = (cnt_q >= term);
        cnt_d   = cnt_q;
        if (adv) begin
            cnt_d = at_term ? '0 : cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_25) begin
        if (!n_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt     = cnt_q;
    assign cnt_nxt = cnt_d;

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: two-mode VGA timing generator with frame-boundary mode switch.
//   clk_25       in  pixel-domain clock
//   n_rst        in  synchronous active-low reset
//   pix_ce       in  pixel clock-enable; counters advance only when high
//   mode_sel     in  requested timing set (0: TIMING0, 1: TIMING1)
//   mode_active  out timing set currently driving the counters
//   mode_pending out switch requested, waiting for the end of the frame
//   hsync/vsync  out syncs at the polarity of the active set
//   video_on     out inside the active picture
//   pixel_x/y    out coordinates
//   line_start   out 1-clk pulse when pixel_x becomes 0
//   frame_start  out 1-clk pulse when (pixel_x, pixel_y) becomes (0,0)
//   frame_cnt    out 16-bit frame counter, only when VGA_FRAME_CNT_EN is defined
// All outputs are registered from the look-ahead coordinates, so they line up
// with pixel_x/pixel_y on the same cycle.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int          CW      = 11,
    parameter vga_timing_t TIMING0 = VGA_640X480,
    parameter vga_timing_t TIMING1 = VGA_800X600
) (
    input  logic          clk_25,
    input  logic          n_rst,
    input  logic          pix_ce,
    input  logic          mode_sel,
    output logic          mode_active,
    output logic          mode_pending,
    output logic          hsync,
    output logic          vsync,
    output logic          video_on,
    output logic [CW-1:0] pixel_x,
    output logic [CW-1:0] pixel_y,
    output logic          line_start,
    output logic          frame_start
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [15:0]   frame_cnt
`endif
);

    // Compare limits of one set, truncated to the counter width.
    typedef struct packed {
        logic [CW-1:0] hvid;
        logic [CW-1:0] hs_beg;
        logic [CW-1:0] hs_end;
        logic [CW-1:0] vvid;
        logic [CW-1:0] vs_beg;
        logic [CW-1:0] vs_end;
        logic          hpol;
        logic          vpol;
    } lim_t;

    function automatic lim_t mk_lim(input vga_timing_t t);
        lim_t        l;
        logic [13:0] hb, he, vb, ve;
        hb = {2'b00, t.hvid} + {2'b00, t.hfp};
        he = hb + {2'b00, t.hs};
        vb = {2'b00, t.vvid} + {2'b00, t.vfp};
        ve = vb + {2'b00, t.vs};
        l.hvid   = CW'(t.hvid);
        l.hs_beg = CW'(hb);
        l.hs_end = CW'(he);
        l.vvid   = CW'(t.vvid);
        l.vs_beg = CW'(vb);
        l.vs_end = CW'(ve);
        l.hpol   = t.hpol;
        l.vpol   = t.vpol;
        return l;
    endfunction

    localparam lim_t          LIM0   = mk_lim(TIMING0);
    localparam lim_t          LIM1   = mk_lim(TIMING1);
    localparam logic [CW-1:0] HTERM0 = CW'(vga_htot(TIMING0) - 14'd1);
    localparam logic [CW-1:0] VTERM0 = CW'(vga_vtot(TIMING0) - 14'd1);
    localparam logic [CW-1:0] HTERM1 = CW'(vga_htot(TIMING1) - 14'd1);
    localparam logic [CW-1:0] VTERM1 = CW'(vga_vtot(TIMING1) - 14'd1);

    if (int'(vga_htot(TIMING0)) > (1 << CW) || int'(vga_vtot(TIMING0)) > (1 << CW) ||
        int'(vga_htot(TIMING1)) > (1 << CW) || int'(vga_vtot(TIMING1)) > (1 << CW))
    begin : g_cfg_err
        $error("vga_timing_gen: a timing set does not fit in CW-bit counters");
    end

    typedef enum logic {RUN = 1'b0, PEND = 1'b1} mode_state_t;

    mode_state_t   state_q, state_d;
    logic          mode_active_q, mode_active_d;
    logic          mode_pending_q, mode_pending_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          video_on_q, video_on_d;
    logic          line_start_q, line_start_d;
    logic          frame_start_q, frame_start_d;

    logic [CW-1:0] x_cnt, y_cnt, x_nxt, y_nxt;
    logic [CW-1:0] hterm, vterm;
    logic          x_end, y_end;
    lim_t          nxt;

    // Counters always wrap against the set currently in force.
    assign hterm = mode_active_q ? HTERM1 : HTERM0;
    assign vterm = mode_active_q ? VTERM1 : VTERM0;

    vga_axis_counter #(.CW(CW)) u_hcnt (
        .clk_25  (clk_25),
        .n_rst   (n_rst),
        .adv     (pix_ce),
        .term    (hterm),
        .cnt     (x_cnt),
        .cnt_nxt (x_nxt),
        .at_term (x_end)
    );

    vga_axis_counter #(.CW(CW)) u_vcnt (
        .clk_25  (clk_25),
        .n_rst   (n_rst),
        .adv     (pix_ce & x_end),
        .term    (vterm),
        .cnt     (y_cnt),
        .cnt_nxt (y_nxt),
        .at_term (y_end)
    );

    always_comb begin
        state_d       = state_q;
        mode_active_d = mode_active_q;
        case (state_q)
            RUN: begin
                if (mode_sel != mode_active_q) state_d = PEND;
            end
            PEND: begin
                // Request withdrawn wins over the boundary; otherwise switch on
                // the last pixel edge of the frame, where both counters wrap.
                if (mode_sel == mode_active_q) begin
                    state_d = RUN;
                end else if (pix_ce && x_end && y_end) begin
                    state_d       = RUN;
                    mode_active_d = mode_sel;
                end
            end
        endcase
        mode_pending_d = (state_d == PEND);

        // Outputs on the switch edge already follow the new set.
        nxt = mode_active_d ? LIM1 : LIM0;

        hsync_d    = hsync_q;
        vsync_d    = vsync_q;
        video_on_d = video_on_q;
        if (pix_ce) begin
            video_on_d = (x_nxt < nxt.hvid) && (y_nxt < nxt.vvid);
            hsync_d    = ((x_nxt >= nxt.hs_beg) && (x_nxt < nxt.hs_end)) ? nxt.hpol : ~nxt.hpol;
            vsync_d    = ((y_nxt >= nxt.vs_beg) && (y_nxt < nxt.vs_end)) ? nxt.vpol : ~nxt.vpol;
        end
        line_start_d  = pix_ce && (x_nxt == '0);
        frame_start_d = line_start_d && (y_nxt == '0);
    end

    always_ff @(posedge clk_25) begin
        if (!n_rst) begin
            state_q        <= RUN;
            mode_active_q  <= 1'b0;
            mode_pending_q <= 1'b0;
            hsync_q        <= ~TIMING0.hpol;
            vsync_q        <= ~TIMING0.vpol;
            video_on_q     <= 1'b0;
            line_start_q   <= 1'b0;
            frame_start_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            mode_active_q  <= mode_active_d;
            mode_pending_q <= mode_pending_d;
            hsync_q        <= hsync_d;
            vsync_q        <= vsync_d;
            video_on_q     <= video_on_d;
            line_start_q   <= line_start_d;
            frame_start_q  <= frame_start_d;
        end
    end

    assign mode_active  = mode_active_q;
    assign mode_pending = mode_pending_q;
    assign hsync        = hsync_q;
    assign vsync        = vsync_q;
    assign video_on     = video_on_q;
    assign pixel_x      = x_cnt;
    assign pixel_y      = y_cnt;
    assign line_start   = line_start_q;
    assign frame_start  = frame_start_q;

`ifdef VGA_FRAME_CNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        frame_cnt_d = frame_start_d ? frame_cnt_q + 16'd1 : frame_cnt_q;
    end

    always_ff @(posedge clk_25) begin
        if (!n_rst) begin
            frame_cnt_q <= 16'd0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

endmodule
